ssd1331_spi_receiver: RTL and testbench
=======================================

Name: ssd1331_spi_receiver

Overview:
SPI mode-0 slave that receives the SSD1331 command/data stream our OLED transmitter produces and decodes it for a simulation display model and on-chip loopback checks. It oversamples spi_sck/spi_mosi/spi_cs/spi_dc in the system clock domain and assembles MSB-first bytes. It tracks multi-byte command arguments, decodes the column/row address window and display on/off, and converts DC=1 data byte pairs into RGB565 pixel writes with window auto-increment.

Parameters:
COL_MAX, 95, reset value of col_end; column coordinates are 7 bits.
ROW_MAX, 63, reset value of row_end; row coordinates are 6 bits.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
spi_cs  input  1  chip select, active low, asynchronous to clk
spi_dc  input  1  0 = command/argument byte, 1 = pixel data byte
spi_mosi  input  1  serial data, MSB first
spi_sck  input  1  serial clock, idle low, sampled on rising edge
byte_valid  output  1  one-cycle strobe per received byte
byte_data  output  8  received byte
byte_dc  output  1  spi_dc sampled at the byte's 8th rising edge
pixel_valid  output  1  one-cycle strobe per completed pixel
pixel_x  output  7  column of the current pixel
pixel_y  output  6  row of the current pixel
pixel_rgb  output  16  RGB565 value, first byte = [15:8]
col_start, col_end  output  7 each  current column window
row_start, row_end  output  6 each  current row window
display_on  output  1  1 after 0xAF, 0 after 0xAE

Behaviour:
- Reset values: byte_valid=0, byte_data=0, byte_dc=0, pixel_valid=0, pixel_x=0, pixel_y=0, pixel_rgb=0, col_start=0, col_end=COL_MAX, row_start=0, row_end=ROW_MAX, display_on=0. The bit counter, argument counter, pixel phase and decoder state all clear. A reset mid-byte discards the partial byte.
- Synchronisation: each SPI input passes through a 2-FF synchroniser. A rising edge is detected from the synchronised sck against a third registered copy.
- Timing constraint: sck high and low phases must each be at least 3 clk cycles.
- Bit assembly: while synchronised cs=0, every sck rising edge shifts mosi into the LSB and increments a 3-bit counter.
- On the 8th bit: the byte is registered into byte_data, byte_dc takes the synchronised dc, and byte_valid pulses 1 cycle.
- Latency: byte_valid rises no later than 4 clk cycles after the raw 8th sck rising edge.
- While synchronised cs=1: the bit counter holds 0 and sck edges are ignored. A cs rise mid-byte discards the partial byte. The argument counter and pixel phase persist across cs toggles.
- Decoder states are IDLE, ARGS, COLARG0, COLARG1, ROWARG0, ROWARG1.
- DC=0 byte in IDLE, i.e. a command:
  - 0x15 -> COLARG0; 0x75 -> ROWARG0.
  - 0xAF sets display_on; 0xAE clears it.
  - Commands taking 1 argument: 0x81,0x82,0x83,0x87,0x8A,0x8B,0x8C,0xA0,0xA1,0xA2,0xA8,0xAD,0xB0,0xB1,0xB3,0xBB,0xBE,0xFD.
  - Multi-argument commands: 0x25 takes 4, 0x21 takes 7, 0x22 takes 10.
  - Any command with arguments loads the argument counter and goes to ARGS; all other commands take 0 arguments and stay in IDLE.
  - Any command byte clears the pixel phase.
- ARGS: each DC=0 byte decrements the counter; at 0 -> IDLE. Arguments appear on the byte port only.
- COLARG0: col_start=byte[6:0] and pixel_x=byte[6:0]. COLARG1: col_end=byte[6:0], -> IDLE. ROWARG0/ROWARG1 do the same for rows with byte[5:0] and pixel_y.
- DC=1 byte in ARGS or an ARG state: the argument sequence aborts, state -> IDLE, and the byte is treated as pixel data.
- Pixel data (DC=1): phase 0 latches the high byte. Phase 1 forms pixel_rgb and pulses pixel_valid 1 cycle after that byte's byte_valid, with the pixel_x/pixel_y of that pixel.
- Auto-increment, the cycle after pixel_valid:
  - if pixel_x==col_end: pixel_x=col_start, and pixel_y = (pixel_y==row_end) ? row_start : pixel_y+1;
  - else pixel_x=pixel_x+1, modulo 128.
  - If start>end, x runs modulo 128 until it equals end.
- Simultaneous events: a cs rise in the same cycle as the 8th edge still delivers the byte. byte_valid and pixel_valid never pulse in the same cycle for the same byte.

Test Plan:
- Reset defaults: pulse reset mid-byte (after 5 bits), then send 0xAF with DC=0 -> no byte_valid for the partial byte; exactly one byte_valid with 0xAF, byte_dc=0; display_on=1; window 0..95/0..63.
- Window and pixels: send 15 10 11 75 20 21, then DC=1 F8 00 07 E0 00 1F 12 34 -> pixels (16,32,F800),(17,32,07E0),(16,33,001F),(17,33,1234).
- Window wrap: after the previous pixel at (17,33), send one more pixel ABCD -> (16,32,ABCD).
- Argument skipping: send 0xA0 0x15 then pixel 0xFFFF -> col_start unchanged at 16 and no pixel emitted until both bytes arrive; 0x15 is consumed as the argument of 0xA0.
- Rectangle arguments: send 22 with 10 arguments, including arguments 0x15 and 0x75 -> window unchanged, 11 byte_valid pulses, state IDLE afterwards.
- CS glitch: raise cs after 3 bits of a pixel low byte, then lower it and resend the full byte -> one pixel with the correct value, and no byte from the aborted fragment.
- Edge-rate limit: sck at clk/6 over 64 bytes -> every byte received and no pixel dropped.

Source files
------------

// File: rtl/ssd1331_spi_receiver.sv
// SPI mode-0 slave for the SSD1331 command/data stream. Oversamples the SPI
// pins in the clk domain, assembles MSB-first bytes, tracks command
// arguments, decodes the address window / display on-off and turns DC=1
// byte pairs into RGB565 pixel writes with window auto-increment.
module ssd1331_spi_receiver #(
  parameter int unsigned COL_MAX = 95,
  parameter int unsigned ROW_MAX = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_cs,
  input  logic        spi_dc,
  input  logic        spi_mosi,
  input  logic        spi_sck,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_dc,
  output logic        pixel_valid,
  output logic [6:0]  pixel_x,
  output logic [5:0]  pixel_y,
  output logic [15:0] pixel_rgb,
  output logic [6:0]  col_start,
  output logic [6:0]  col_end,
  output logic [5:0]  row_start,
  output logic [5:0]  row_end,
  output logic        display_on
);

  typedef enum logic [2:0] {
    StIdle,
    StArgs,
    StColArg0,
    StColArg1,
    StRowArg0,
    StRowArg1
  } dec_state_e;

  // Number of argument bytes following a command (0x15/0x75 handled separately).
  function automatic logic [3:0] arg_count(input logic [7:0] cmd);
    logic [3:0] n;
    n = 4'd0;
    case (cmd)
      8'h81, 8'h82, 8'h83, 8'h87, 8'h8A, 8'h8B, 8'h8C, 8'hA0, 8'hA1,
      8'hA2, 8'hA8, 8'hAD, 8'hB0, 8'hB1, 8'hB3, 8'hBB, 8'hBE, 8'hFD: n = 4'd1;
      8'h25:   n = 4'd4;
      8'h21:   n = 4'd7;
      8'h22:   n = 4'd10;
      default: n = 4'd0;
    endcase
    return n;
  endfunction

  logic [1:0] cs_sync_q, dc_sync_q, mosi_sync_q, sck_sync_q;
  logic       sck_q, cs_q;
  logic       sck_rise, cs_active;

  // Two-flop synchronisers plus one extra stage of sck/cs for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sync_q   <= 2'b11;
      dc_sync_q   <= 2'b00;
      mosi_sync_q <= 2'b00;
      sck_sync_q  <= 2'b00;
      sck_q       <= 1'b0;
      cs_q        <= 1'b1;
    end else begin
      cs_sync_q   <= {cs_sync_q[0], spi_cs};
      dc_sync_q   <= {dc_sync_q[0], spi_dc};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
      sck_sync_q  <= {sck_sync_q[0], spi_sck};
      sck_q       <= sck_sync_q[1];
      cs_q        <= cs_sync_q[1];
    end
  end

  assign sck_rise  = sck_sync_q[1] & ~sck_q;
  // Stay active for one cycle after cs rises so an 8th edge coinciding with
  // the cs rise still completes its byte.
  assign cs_active = ~cs_sync_q[1] | ~cs_q;

  logic [2:0] bit_cnt_q;
  logic [6:0] shift_q;

  // Bit assembly: shift on each qualified sck rise, emit a byte on the 8th.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_q  <= 3'd0;
      shift_q    <= 7'd0;
      byte_valid <= 1'b0;
      byte_data  <= 8'd0;
      byte_dc    <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (sck_rise && cs_active) begin
        shift_q   <= {shift_q[5:0], mosi_sync_q[1]};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_valid <= 1'b1;
          byte_data  <= {shift_q, mosi_sync_q[1]};
          byte_dc    <= dc_sync_q[1];
        end
      end else if (!cs_active) begin
        bit_cnt_q <= 3'd0;
      end
    end
  end

  dec_state_e state_q;
  logic [3:0] arg_cnt_q;
  logic       pix_phase_q;
  logic [7:0] pix_hi_q;

  // Command/argument decoder, window registers and pixel assembly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      arg_cnt_q   <= 4'd0;
      pix_phase_q <= 1'b0;
      pix_hi_q    <= 8'd0;
      pixel_valid <= 1'b0;
      pixel_x     <= 7'd0;
      pixel_y     <= 6'd0;
      pixel_rgb   <= 16'd0;
      col_start   <= 7'd0;
      col_end     <= 7'(COL_MAX);
      row_start   <= 6'd0;
      row_end     <= 6'(ROW_MAX);
      display_on  <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;

      // Advance to the next window position after each pixel.
      if (pixel_valid) begin
        if (pixel_x == col_end) begin
          pixel_x <= col_start;
          pixel_y <= (pixel_y == row_end) ? row_start : pixel_y + 6'd1;
        end else begin
          pixel_x <= pixel_x + 7'd1;
        end
      end

      if (byte_valid && !byte_dc) begin
        unique case (state_q)
          StIdle: begin
            pix_phase_q <= 1'b0;
            if (byte_data == 8'h15) begin
              state_q <= StColArg0;
            end else if (byte_data == 8'h75) begin
              state_q <= StRowArg0;
            end else if (arg_count(byte_data) != 4'd0) begin
              arg_cnt_q <= arg_count(byte_data);
              state_q   <= StArgs;
            end
            if (byte_data == 8'hAF) display_on <= 1'b1;
            if (byte_data == 8'hAE) display_on <= 1'b0;
          end
          StArgs: begin
            arg_cnt_q <= arg_cnt_q - 4'd1;
            if (arg_cnt_q == 4'd1) state_q <= StIdle;
          end
          StColArg0: begin
            col_start <= byte_data[6:0];
            pixel_x   <= byte_data[6:0];
            state_q   <= StColArg1;
          end
          StColArg1: begin
            col_end <= byte_data[6:0];
            state_q <= StIdle;
          end
          StRowArg0: begin
            row_start <= byte_data[5:0];
            pixel_y   <= byte_data[5:0];
            state_q   <= StRowArg1;
          end
          StRowArg1: begin
            row_end <= byte_data[5:0];
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end else if (byte_valid) begin
        // Pixel data aborts any pending argument sequence.
        state_q <= StIdle;
        if (!pix_phase_q) begin
          pix_hi_q    <= byte_data;
          pix_phase_q <= 1'b1;
        end else begin
          pixel_rgb   <= {pix_hi_q, byte_data};
          pixel_valid <= 1'b1;
          pix_phase_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ssd1331_spi_receiver.sv
// Self-checking bench for ssd1331_spi_receiver: directed and random SPI
// streams compared against a byte-level behavioural model of the decoder.
module tb_ssd1331_spi_receiver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spi_cs = 1'b1;
  logic        spi_dc = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_sck = 1'b0;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_dc;
  logic        pixel_valid;
  logic [6:0]  pixel_x;
  logic [5:0]  pixel_y;
  logic [15:0] pixel_rgb;
  logic [6:0]  col_start, col_end;
  logic [5:0]  row_start, row_end;
  logic        display_on;

  ssd1331_spi_receiver #(.COL_MAX(95), .ROW_MAX(63)) dut (
    .clk        (clk),
    .reset      (reset),
    .spi_cs     (spi_cs),
    .spi_dc     (spi_dc),
    .spi_mosi   (spi_mosi),
    .spi_sck    (spi_sck),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_dc    (byte_dc),
    .pixel_valid(pixel_valid),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .pixel_rgb  (pixel_rgb),
    .col_start  (col_start),
    .col_end    (col_end),
    .row_start  (row_start),
    .row_end    (row_end),
    .display_on (display_on)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int overlap = 0;

  logic [8:0]  got_bytes[$];
  logic [8:0]  exp_bytes[$];
  logic [28:0] got_pix[$];
  logic [28:0] exp_pix[$];

  // Monitor: record every byte and pixel event.
  always @(negedge clk) begin
    if (byte_valid) got_bytes.push_back({byte_dc, byte_data});
    if (pixel_valid) got_pix.push_back({pixel_x, pixel_y, pixel_rgb});
    if (byte_valid && pixel_valid) overlap++;
  end

  // Behavioural model state: what the display controller should believe.
  int   m_mode;       // 0 command, 1 skipping args, 2/3 col args, 4/5 row args
  int   m_skip;
  int   m_cs, m_ce, m_rs, m_re, m_x, m_y;
  bit   m_disp, m_have_hi;
  int   m_hi;

  function automatic int cmd_args(input int c);
    case (c)
      'h81, 'h82, 'h83, 'h87, 'h8A, 'h8B, 'h8C, 'hA0, 'hA1,
      'hA2, 'hA8, 'hAD, 'hB0, 'hB1, 'hB3, 'hBB, 'hBE, 'hFD: return 1;
      'h25:    return 4;
      'h21:    return 7;
      'h22:    return 10;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_skip = 0;
    m_cs = 0; m_ce = 95; m_rs = 0; m_re = 63; m_x = 0; m_y = 0;
    m_disp = 0; m_have_hi = 0; m_hi = 0;
    exp_bytes.delete();
    exp_pix.delete();
  endtask

  task automatic model_byte(input bit dc, input int b);
    exp_bytes.push_back({dc, 8'(b)});
    if (!dc) begin
      case (m_mode)
        0: begin
          m_have_hi = 0;
          if (b == 'h15) m_mode = 2;
          else if (b == 'h75) m_mode = 4;
          else if (cmd_args(b) > 0) begin m_skip = cmd_args(b); m_mode = 1; end
          if (b == 'hAF) m_disp = 1;
          if (b == 'hAE) m_disp = 0;
        end
        1: begin m_skip--; if (m_skip == 0) m_mode = 0; end
        2: begin m_cs = b % 128; m_x = m_cs; m_mode = 3; end
        3: begin m_ce = b % 128; m_mode = 0; end
        4: begin m_rs = b % 64; m_y = m_rs; m_mode = 5; end
        default: begin m_re = b % 64; m_mode = 0; end
      endcase
    end else begin
      m_mode = 0;
      if (!m_have_hi) begin
        m_hi = b; m_have_hi = 1;
      end else begin
        exp_pix.push_back({7'(m_x), 6'(m_y), 8'(m_hi), 8'(b)});
        m_have_hi = 0;
        if (m_x == m_ce) begin
          m_x = m_cs;
          m_y = (m_y == m_re) ? m_rs : (m_y + 1) % 64;
        end else begin
          m_x = (m_x + 1) % 128;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input bit dc, input logic [7:0] b, input int nbits, input int half);
    spi_dc = dc;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = b[7-i];
      wait_clk(half);
      spi_sck = 1'b1;
      wait_clk(half);
      spi_sck = 1'b0;
    end
  endtask

  task automatic send_byte(input bit dc, input int b, input int half);
    send_bits(dc, 8'(b), 8, half);
    model_byte(dc, b);
  endtask

  // Final edge coincides with cs rising; the byte must still be delivered.
  task automatic send_byte_cs_rise(input bit dc, input int b);
    logic [7:0] v;
    v = 8'(b);
    send_bits(dc, v, 7, 4);
    spi_mosi = v[0];
    wait_clk(4);
    spi_sck = 1'b1;
    spi_cs  = 1'b1;
    wait_clk(4);
    spi_sck = 1'b0;
    model_byte(dc, b);
    wait_clk(4);
    spi_cs = 1'b0;
    wait_clk(4);
  endtask

  task automatic check_stream(input string tag);
    int n;
    wait_clk(12);
    chk($sformatf("%s byte count", tag), got_bytes.size(), exp_bytes.size());
    n = (got_bytes.size() < exp_bytes.size()) ? got_bytes.size() : exp_bytes.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s byte[%0d]", tag, i), 32'(got_bytes[i]), 32'(exp_bytes[i]));
    chk($sformatf("%s pixel count", tag), got_pix.size(), exp_pix.size());
    n = (got_pix.size() < exp_pix.size()) ? got_pix.size() : exp_pix.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s pixel[%0d]", tag, i), 32'(got_pix[i]), 32'(exp_pix[i]));
    chk($sformatf("%s col_start", tag), 32'(col_start), m_cs);
    chk($sformatf("%s col_end", tag), 32'(col_end), m_ce);
    chk($sformatf("%s row_start", tag), 32'(row_start), m_rs);
    chk($sformatf("%s row_end", tag), 32'(row_end), m_re);
    chk($sformatf("%s display_on", tag), 32'(display_on), 32'(m_disp));
    got_bytes.delete(); exp_bytes.delete();
    got_pix.delete();   exp_pix.delete();
  endtask

  logic [7:0] cmds [8] = '{8'h15, 8'h75, 8'hA0, 8'hAF, 8'hAE, 8'h81, 8'h25, 8'h00};

  initial begin
    model_reset();
    wait_clk(4);
    reset = 1'b0;
    wait_clk(2);

    // Reset state
    chk("rst byte_valid", 32'(byte_valid), 0);
    chk("rst byte_data", 32'(byte_data), 0);
    chk("rst byte_dc", 32'(byte_dc), 0);
    chk("rst pixel_valid", 32'(pixel_valid), 0);
    chk("rst pixel_x", 32'(pixel_x), 0);
    chk("rst pixel_y", 32'(pixel_y), 0);
    chk("rst pixel_rgb", 32'(pixel_rgb), 0);
    chk("rst col_end", 32'(col_end), 95);
    chk("rst row_end", 32'(row_end), 63);
    chk("rst display_on", 32'(display_on), 0);

    // Reset mid-byte discards the partial byte
    spi_cs = 1'b0;
    wait_clk(4);
    send_bits(1'b0, 8'h5A, 5, 4);
    wait_clk(3);
    reset = 1'b1;
    wait_clk(2);
    reset = 1'b0;
    model_reset();
    wait_clk(4);
    send_byte(1'b0, 'hAF, 4);
    check_stream("reset");

    // Window setup and four pixels
    foreach (cmds[i]) if (i < 0) $display("unused");
    send_byte(1'b0, 'h15, 4); send_byte(1'b0, 'h10, 4); send_byte(1'b0, 'h11, 4);
    send_byte(1'b0, 'h75, 4); send_byte(1'b0, 'h20, 4); send_byte(1'b0, 'h21, 4);
    send_byte(1'b1, 'hF8, 4); send_byte(1'b1, 'h00, 4);
    send_byte(1'b1, 'h07, 4); send_byte(1'b1, 'hE0, 4);
    send_byte(1'b1, 'h00, 4); send_byte(1'b1, 'h1F, 4);
    send_byte(1'b1, 'h12, 4); send_byte(1'b1, 'h34, 4);
    check_stream("window");

    // Window wrap back to (16,32)
    send_byte(1'b1, 'hAB, 4); send_byte(1'b1, 'hCD, 4);
    check_stream("wrap");

    // 0x15 consumed as the argument of 0xA0
    send_byte(1'b0, 'hA0, 4); send_byte(1'b0, 'h15, 4);
    send_byte(1'b1, 'hFF, 4); send_byte(1'b1, 'hFF, 4);
    check_stream("argskip");

    // Rectangle command with 10 arguments, then 0xAE proves the decoder is idle
    send_byte(1'b0, 'h22, 4);
    for (int i = 0; i < 10; i++) begin
      int a;
      a = (i == 2) ? 'h15 : (i == 5) ? 'h75 : int'($urandom_range(0, 255));
      send_byte(1'b0, a, 4);
    end
    send_byte(1'b0, 'hAE, 4);
    check_stream("rect");

    // CS glitch in the middle of a pixel low byte
    send_byte(1'b1, 'h5A, 4);
    send_bits(1'b1, 8'hC3, 3, 4);
    wait_clk(3);
    spi_cs = 1'b1;
    wait_clk(8);
    spi_cs = 1'b0;
    wait_clk(4);
    send_byte(1'b1, 'hC3, 4);
    check_stream("csglitch");

    // cs rising together with the 8th sck edge
    send_byte(1'b1, 'h81, 4);
    send_byte_cs_rise(1'b1, 'h7E);
    check_stream("csrise");

    // Random mix at the fastest legal sck rate (clk/6)
    for (int i = 0; i < 64; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 6) send_byte(1'b1, int'($urandom_range(0, 255)), 3);
      else if (r < 8) send_byte(1'b0, int'(cmds[$urandom_range(0, 7)]), 3);
      else send_byte(1'b0, int'($urandom_range(0, 255)), 3);
    end
    check_stream("random");

    chk("byte/pixel overlap", overlap, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
